// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and responder FSM states for the SRAM slave.
// The optional error responder (ERR1/ERR2) is built only with AHBSLV_ERR_RESP_EN.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Expand a 4-bit byte-lane strobe into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{lanes[i]}};
    return m;
  endfunction

endpackage

// File: rtl/ahblite_byte_lane_gen.sv
// Little-endian byte-lane strobe generator for AHB-Lite transfers.
// Sizes above word select all four lanes; misaligned flags half/word offsets.
module ahblite_byte_lane_gen
  import ahblite_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes,
  output logic       misaligned
);

  always_comb begin
    lanes      = 4'b1111;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lanes      = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite register-array SRAM responder with programmable data-phase wait states.
// Define AHBSLV_ERR_RESP_EN to answer out-of-range/oversize/misaligned transfers with ERROR.
module ahblite_sram_slave
  import ahblite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [2:0]            state_dbg
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Handshake: an address phase is taken only on a rising edge where HSEL, HREADY
  // and HTRANS[1] are all high; a data phase completes on the edge where HREADYOUT=1.
  state_t              state, state_next, accept_target;
  logic [2:0]          wait_cnt;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic                write_q;
  logic [3:0]          lanes_q;
  logic                in_range_q;
  logic [3:0]          lanes;
  logic                misaligned;
  logic                req_in_range;
  logic                req_err;
  logic                accept;
  logic                take;
  logic [31:0]         mem [MEM_DEPTH];
  logic                unused_bits;

  ahblite_byte_lane_gen u_lane_gen (
    .hsize      (HSIZE),
    .addr_lo    (HADDR[1:0]),
    .lanes      (lanes),
    .misaligned (misaligned)
  );

  assign req_in_range = 32'(HADDR[ADDR_WIDTH-1:2]) < 32'(MEM_DEPTH);

`ifdef AHBSLV_ERR_RESP_EN
  assign req_err     = !req_in_range || (HSIZE > HSIZE_WORD) || misaligned;
  assign unused_bits = HTRANS[0];
`else
  assign req_err     = 1'b0;
  assign unused_bits = HTRANS[0] ^ misaligned;
`endif

  assign accept = HSEL & HREADY & HTRANS[1];
  assign take   = accept & ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2));

  always_comb begin
    accept_target = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
    if (req_err) accept_target = ST_ERR1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: state_next = take ? accept_target : ST_IDLE;
      ST_WAIT:                   if (wait_cnt <= 3'd1) state_next = ST_DATA;
      ST_ERR1:                   state_next = ST_ERR2;
      default:                   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wait_cnt <= 3'd0;
    end else if (take) begin
      wait_cnt <= 3'(WAIT_STATES);
    end else if (state == ST_WAIT && wait_cnt != 3'd0) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mem_addr_q <= '0;
      write_q    <= 1'b0;
      lanes_q    <= 4'b0000;
      in_range_q <= 1'b0;
    end else if (take) begin
      mem_addr_q <= MEM_AW'(HADDR[ADDR_WIDTH-1:2]);
      write_q    <= HWRITE;
      lanes_q    <= lanes;
      in_range_q <= req_in_range;
    end
  end

  // The array has no reset; the HRESET gate drops a write caught by reset.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == ST_DATA && write_q && in_range_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes_q[i]) mem[mem_addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_DATA: if (!write_q && in_range_q) HRDATA = mem[mem_addr_q] & lane_mask(lanes_q);
`ifdef AHBSLV_ERR_RESP_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Scoreboard bench for ahblite_sram_slave: one zero-wait and one 3-wait instance on a shared bus.
// Honours AHBSLV_ERR_RESP_EN for the out-of-range / misaligned checks.
module tb_ahblite_sram_slave;
  import ahblite_pkg::*;

  localparam int AW = 12;
  localparam int EW = 38;  // {waits[3:0], resp, is_read, data[31:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel3;
  logic          b_hsel;
  logic [AW-1:0] b_haddr;
  logic [1:0]    b_htrans;
  logic          b_hwrite;
  logic [2:0]    b_hsize;
  logic [31:0]   b_hwdata;

  logic          r0_ready, r0_resp, r3_ready, r3_resp;
  logic [31:0]   r0_rdata, r3_rdata;
  logic [2:0]    r0_state, r3_state;
  logic          hsel0, hsel3;
  logic          m_ready, m_resp;
  logic [31:0]   m_rdata;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  assign hsel0   = b_hsel & ~sel3;
  assign hsel3   = b_hsel & sel3;
  assign m_ready = sel3 ? r3_ready : r0_ready;
  assign m_resp  = sel3 ? r3_resp  : r0_resp;
  assign m_rdata = sel3 ? r3_rdata : r0_rdata;

  ahblite_sram_slave #(.ADDR_WIDTH(AW), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HWRITE(b_hwrite), .HSIZE(b_hsize), .HWDATA(b_hwdata), .HREADY(r0_ready),
    .HREADYOUT(r0_ready), .HRESP(r0_resp), .HRDATA(r0_rdata), .state_dbg(r0_state)
  );

  ahblite_sram_slave #(.ADDR_WIDTH(AW), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(b_haddr), .HTRANS(b_htrans),
    .HWRITE(b_hwrite), .HSIZE(b_hsize), .HWDATA(b_hwdata), .HREADY(r3_ready),
    .HREADYOUT(r3_ready), .HRESP(r3_resp), .HRDATA(r3_rdata), .state_dbg(r3_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input bit err, input bit is_rd, input logic [31:0] d);
    int w;
    w = err ? 1 : (sel3 ? 3 : 0);
    return {4'(w), err, is_rd, d};
  endfunction

  // Drive one address phase, hold until accepted, then put its write data on the bus.
  task automatic addr_phase(input logic [1:0] t, input logic wr, input logic [AW-1:0] a,
                            input logic [2:0] sz, input logic [31:0] wd, input logic [EW-1:0] e);
    int n;
    b_hsel = 1'b1; b_htrans = t; b_hwrite = wr; b_haddr = a; b_hsize = sz;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: addr 0x%03h not accepted within 50 cycles", a);
    end
    @(posedge clk);
    #1;
    b_hwdata = wd;
    b_hsel   = 1'b0;
    b_htrans = HTRANS_IDLE;
  endtask

  task automatic wr(input logic [1:0] t, input logic [AW-1:0] a, input logic [2:0] sz,
                    input logic [31:0] d, input bit err);
    addr_phase(t, 1'b1, a, sz, d, pack(err, 1'b0, 32'h0));
  endtask

  task automatic rd(input logic [1:0] t, input logic [AW-1:0] a, input logic [2:0] sz,
                    input logic [31:0] d, input bit err);
    addr_phase(t, 1'b0, a, sz, 32'h0, pack(err, 1'b1, err ? 32'h0 : d));
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    b_hsel = 1'b0;
    b_htrans = HTRANS_IDLE;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts wait cycles of each data phase and compares on its completing cycle.
  initial begin : monitor
    bit            dp;
    int            waits;
    logic [EW-1:0] e;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        dp = 1'b0;
        continue;
      end
      if (dp) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_response: got data phase with empty queue");
          end else begin
            e = exp_q.pop_front();
            check("wait_cycles", 32'(waits), 32'(e[37:34]));
            check("hresp", 32'(m_resp), 32'(e[33]));
            if (e[32]) check("hrdata", m_rdata, e[31:0]);
          end
          dp = 1'b0;
        end else begin
          waits++;
          if (exp_q.size() != 0) check("hresp_wait", 32'(m_resp), 32'(exp_q[0][33]));
          if (waits > 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL stuck_wait: HREADYOUT low for %0d cycles, required <= 20", waits);
            dp = 1'b0;
          end
        end
      end
      if (b_hsel && b_htrans != HTRANS_IDLE && m_ready) begin
        dp = 1'b1;
        waits = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; sel3 = 1'b0;
    b_hsel = 1'b0; b_haddr = '0; b_htrans = HTRANS_IDLE; b_hwrite = 1'b0;
    b_hsize = HSIZE_WORD; b_hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", 32'(r0_ready), 32'd1);
    check("rst_resp0",  32'(r0_resp),  32'd0);
    check("rst_rdata0", r0_rdata,      32'h0);
    check("rst_state0", 32'(r0_state), 32'(ST_IDLE));
    check("rst_ready3", 32'(r3_ready), 32'd1);
    check("rst_rdata3", r3_rdata,      32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait write then back-to-back read of the same word.
    wr(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    rd(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    idle_wait();

    // Byte and halfword lane merging, narrow reads zero inactive lanes.
    wr(HTRANS_NONSEQ, 12'h012, HSIZE_BYTE, 32'h00A5_0000, 1'b0);
    rd(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEA5_BEEF, 1'b0);
    wr(HTRANS_NONSEQ, 12'h010, HSIZE_HALF, 32'h0000_1234, 1'b0);
    rd(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEA5_1234, 1'b0);
    rd(HTRANS_NONSEQ, 12'h013, HSIZE_BYTE, 32'hDE00_0000, 1'b0);
    rd(HTRANS_NONSEQ, 12'h012, HSIZE_HALF, 32'hDEA5_0000, 1'b0);
    idle_wait();

    // Burst writes with a BUSY beat between them.
    wr(HTRANS_NONSEQ, 12'h020, HSIZE_WORD, 32'h1111_1111, 1'b0);
    addr_phase(HTRANS_BUSY, 1'b1, 12'h024, HSIZE_WORD, 32'hFFFF_FFFF, pack(1'b0, 1'b0, 32'h0));
    wr(HTRANS_SEQ,    12'h024, HSIZE_WORD, 32'h2222_2222, 1'b0);
    rd(HTRANS_NONSEQ, 12'h020, HSIZE_WORD, 32'h1111_1111, 1'b0);
    rd(HTRANS_NONSEQ, 12'h024, HSIZE_WORD, 32'h2222_2222, 1'b0);
    idle_wait();

    // Out-of-range and misaligned accesses; word 256 would alias word 0 if truncated.
    wr(HTRANS_NONSEQ, 12'h000, HSIZE_WORD, 32'h1357_9BDF, 1'b0);
`ifdef AHBSLV_ERR_RESP_EN
    rd(HTRANS_NONSEQ, 12'h002, HSIZE_WORD, 32'h0, 1'b1);
    wr(HTRANS_NONSEQ, 12'h400, HSIZE_WORD, 32'hCAFE_F00D, 1'b1);
    rd(HTRANS_NONSEQ, 12'h400, HSIZE_WORD, 32'h0, 1'b1);
    rd(HTRANS_NONSEQ, 12'h011, HSIZE_HALF, 32'h0, 1'b1);
    rd(HTRANS_NONSEQ, 12'h000, HSIZE_WORD, 32'h1357_9BDF, 1'b0);
`else
    wr(HTRANS_NONSEQ, 12'h400, HSIZE_WORD, 32'hCAFE_F00D, 1'b0);
    rd(HTRANS_NONSEQ, 12'h400, HSIZE_WORD, 32'h0, 1'b0);
    rd(HTRANS_NONSEQ, 12'h000, HSIZE_WORD, 32'h1357_9BDF, 1'b0);
    rd(HTRANS_NONSEQ, 12'h002, HSIZE_WORD, 32'h1357_9BDF, 1'b0);
`endif
    idle_wait();

    // Three wait states.
    sel3 = 1'b1;
    wr(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    rd(HTRANS_NONSEQ, 12'h010, HSIZE_WORD, 32'hDEAD_BEEF, 1'b0);
    wr(HTRANS_NONSEQ, 12'h030, HSIZE_WORD, 32'hAAAA_AAAA, 1'b0);
    idle_wait();

    // Reset in the middle of a waited write: outputs drop to reset values, write discarded.
    b_hsel = 1'b1; b_htrans = HTRANS_NONSEQ; b_hwrite = 1'b1;
    b_haddr = 12'h030; b_hsize = HSIZE_WORD;
    @(posedge clk);
    #1;
    b_hwdata = 32'h5555_5555; b_hsel = 1'b0; b_htrans = HTRANS_IDLE;
    @(negedge clk);
    check("abort_in_wait", 32'(r3_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("abort_ready", 32'(r3_ready), 32'd1);
    check("abort_resp",  32'(r3_resp),  32'd0);
    check("abort_rdata", r3_rdata,      32'h0);
    check("abort_state", 32'(r3_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rd(HTRANS_NONSEQ, 12'h030, HSIZE_WORD, 32'hAAAA_AAAA, 1'b0);
    idle_wait();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
